subleq_pc_stack: RTL and testbench
==================================

// Module: subleq_pc_stack
// PURPOSE
//  Parametrised program counter for the subleq core, replacing the fixed-width PC.
//  Adds stall, call/return with a hardware return-address stack, halt detection
//  (jump-to-self or negative target), a configurable reset vector and step size.
//  It sits between the sequencer FSM, which drives the control strobes, and the
//  memory address mux, which consumes pc_out.
// PARAMETERS
//  WORD_SIZE    16  width of pc and all addresses
//  RESET_ADDR   0   pc value loaded on reset
//  STEP         1   amount added to pc per inc strobe, taken mod 2^WORD_SIZE
//  STACK_DEPTH  4   return-stack entries, >=1
//  HALT_ON_NEG  1   1 = a branch or call target with MSB set halts the core
// PORTS
//  clk        in   1          clock, rising edge
//  areset     in   1          reset, synchronous, active-high
//  en         in   1          0 = stall: all state holds
//  inc        in   1          advance pc by STEP
//  branch     in   1          load pc <= addr
//  call       in   1          push pc+STEP, then load pc <= addr
//  ret        in   1          pop the top of stack into pc
//  addr       in   WORD_SIZE  branch/call target
//  pc_out     out  WORD_SIZE  current pc (registered)
//  halted     out  1          sticky halt flag
//  stk_ovf    out  1          sticky flag: call while stack full
//  stk_unf    out  1          sticky flag: ret while stack empty
//  stk_depth  out  clog2(STACK_DEPTH+1)  number of valid stack entries
// BEHAVIOUR
//  - Reset is clocked. areset=1 at a rising edge sets pc=RESET_ADDR, halted=0,
//    stk_ovf=0, stk_unf=0 and stk_depth=0. It overrides every other input,
//    including halted and en=0. Stack contents are don't-care after reset.
//  - All outputs come straight from registers. An action sampled at edge N is
//    visible on pc_out after edge N. No combinational path runs from inputs to outputs.
//  - Per edge, the first matching rule applies:
//    areset > halted (hold all) > !en (hold all) > ret > call > branch > inc > hold.
//  - Only the highest-priority strobe acts. Lower strobes asserted in the same
//    cycle are ignored; for example, ret+call pops only.
//  - inc: pc <= pc + STEP, wrapping mod 2^WORD_SIZE. 16'hFFFF + 1 gives 0.
//  - branch: the target is addr.
//    * If addr==pc, or HALT_ON_NEG=1 and addr[MSB]=1: halted <= 1 and pc <= addr.
//    * Otherwise pc <= addr.
//  - call: the same target and halt rules as branch apply.
//    * If stk_depth<STACK_DEPTH, push pc+STEP (wrapped) and increment stk_depth.
//    * If the stack is full, stk_ovf <= 1, the push is dropped, and the stack is unchanged.
//    * The jump occurs in either case.
//    * A call that halts still performs the push.
//  - ret: if stk_depth>0, pc <= top entry and decrement stk_depth.
//    * If the stack is empty, stk_unf <= 1 and pc <= pc + STEP.
//    * A popped value never triggers a halt.
//  - The stack is LIFO, implemented as a register array with a depth pointer.
//    No combinational read of stale entries occurs.
//  - halted is terminal: pc, the stack and the flags freeze until areset.
//  - The flags are sticky until areset.
//  - A reset asserted mid-sequence, for example between a call and its ret, discards all stack state.
// TESTING
//  1 Reset: areset=1 for 1 clk with RESET_ADDR=16'h0010 -> pc_out=0010, halted=0, stk_depth=0.
//  2 Inc/wrap: pc=FFFE, inc x3 -> pc_out FFFF, 0000, 0001. With en=0 and inc=1 for 2 clks -> pc_out holds 0001.
//  3 Call/ret: pc=0005, call addr=0040 -> pc_out=0040, depth=1. Then ret -> pc_out=0006, depth=0.
//  4 Overflow/underflow (depth 4): 5 nested calls -> stk_ovf=1, depth=4, pc_out=5th target.
//    Then 5 rets -> 4 LIFO return addresses, then stk_unf=1 and pc_out=last+1.
//  5 Halt: branch addr=pc -> halted=1. Later inc, branch and call -> no change.
//    Separately, branch addr=8000 with HALT_ON_NEG=1 -> halted=1, pc_out=8000.
//  6 Priority: ret+call+branch with depth=1 and top=0033 -> pc_out=0033, depth=0.
//    Then areset together with inc -> pc_out=RESET_ADDR.

Source files
------------

// File: rtl/subleq_pc_stack.sv
// Program counter for the subleq core: stall, inc, branch, call/return through a
// hardware return-address stack, sticky halt and stack overflow/underflow flags.
module subleq_pc_stack #(
  parameter int                   WORD_SIZE   = 16,
  parameter logic [WORD_SIZE-1:0] RESET_ADDR  = '0,
  parameter int                   STEP        = 1,
  parameter int                   STACK_DEPTH = 4,
  parameter bit                   HALT_ON_NEG = 1'b1
) (
  input  logic                               clk,
  input  logic                               areset,
  input  logic                               en,
  input  logic                               inc,
  input  logic                               branch,
  input  logic                               call,
  input  logic                               ret,
  input  logic [WORD_SIZE-1:0]               addr,
  output logic [WORD_SIZE-1:0]               pc_out,
  output logic                               halted,
  output logic                               stk_ovf,
  output logic                               stk_unf,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_depth
);

  localparam int                   DW     = $clog2(STACK_DEPTH + 1);
  localparam int                   SLOTS  = 1 << DW;
  localparam logic [WORD_SIZE-1:0] STEP_W = WORD_SIZE'(STEP);
  localparam logic [DW-1:0]        FULL   = DW'(STACK_DEPTH);

  // Sized to the full pointer range so the depth pointer indexes it directly;
  // slots at or above STACK_DEPTH are never written.
  logic [WORD_SIZE-1:0] stack [SLOTS];

  logic [WORD_SIZE-1:0] pc_seq;
  logic [DW-1:0]        top_idx;
  logic                 target_halt;
  logic                 active;
  logic                 do_push;

  assign pc_seq      = pc_out + STEP_W;
  assign top_idx     = stk_depth - DW'(1);
  assign target_halt = (addr == pc_out) || (HALT_ON_NEG && addr[WORD_SIZE-1]);
  assign active      = !areset && !halted && en;
  assign do_push     = active && !ret && call && (stk_depth != FULL);

  always_ff @(posedge clk) begin
    if (do_push) stack[stk_depth] <= pc_seq;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      pc_out    <= RESET_ADDR;
      halted    <= 1'b0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
      stk_depth <= '0;
    end else if (active) begin
      if (ret) begin
        if (stk_depth != '0) begin
          pc_out    <= stack[top_idx];
          stk_depth <= top_idx;
        end else begin
          stk_unf <= 1'b1;
          pc_out  <= pc_seq;
        end
      end else if (call) begin
        // The jump happens whether or not the return address fits.
        if (stk_depth != FULL) stk_depth <= stk_depth + DW'(1);
        else                   stk_ovf   <= 1'b1;
        pc_out <= addr;
        if (target_halt) halted <= 1'b1;
      end else if (branch) begin
        pc_out <= addr;
        if (target_halt) halted <= 1'b1;
      end else if (inc) begin
        pc_out <= pc_seq;
      end
    end
  end

endmodule

// File: tb/tb_subleq_pc_stack.sv
// Bench for subleq_pc_stack: directed scenarios plus random strobes, two
// instances (negative-target halt on/off) checked against a behavioural model.
module tb_subleq_pc_stack;

  logic        clk = 1'b0;
  logic        areset, en, inc, branch, call, ret;
  logic [15:0] addr;

  logic [15:0] pc_a, pc_b;
  logic        halted_a, halted_b, ovf_a, ovf_b, unf_a, unf_b;
  logic [2:0]  dep_a, dep_b;

  subleq_pc_stack #(.WORD_SIZE(16), .RESET_ADDR(16'h0010), .STEP(1),
                    .STACK_DEPTH(4), .HALT_ON_NEG(1'b1)) dut_a (
    .clk(clk), .areset(areset), .en(en), .inc(inc), .branch(branch),
    .call(call), .ret(ret), .addr(addr), .pc_out(pc_a), .halted(halted_a),
    .stk_ovf(ovf_a), .stk_unf(unf_a), .stk_depth(dep_a));

  subleq_pc_stack #(.WORD_SIZE(16), .RESET_ADDR(16'hFFFE), .STEP(1),
                    .STACK_DEPTH(4), .HALT_ON_NEG(1'b0)) dut_b (
    .clk(clk), .areset(areset), .en(en), .inc(inc), .branch(branch),
    .call(call), .ret(ret), .addr(addr), .pc_out(pc_b), .halted(halted_b),
    .stk_ovf(ovf_b), .stk_unf(unf_b), .stk_depth(dep_b));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per instance: index 0 = dut_a, 1 = dut_b.
  logic [15:0] m_pc  [2];
  bit          m_halt[2];
  bit          m_ovf [2];
  bit          m_unf [2];
  int          m_n   [2];
  logic [15:0] m_stk [2][4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic [15:0] seq;
    bit          hit;
    seq = m_pc[k] + 16'd1;
    hit = (addr == m_pc[k]) || ((k == 0) && addr[15]);
    if (areset) begin
      m_pc[k]   = (k == 0) ? 16'h0010 : 16'hFFFE;
      m_halt[k] = 0;
      m_ovf[k]  = 0;
      m_unf[k]  = 0;
      m_n[k]    = 0;
    end else if (!m_halt[k] && en) begin
      if (ret) begin
        if (m_n[k] > 0) begin
          m_n[k]--;
          m_pc[k] = m_stk[k][m_n[k]];
        end else begin
          m_unf[k] = 1;
          m_pc[k]  = seq;
        end
      end else if (call) begin
        if (m_n[k] < 4) begin
          m_stk[k][m_n[k]] = seq;
          m_n[k]++;
        end else begin
          m_ovf[k] = 1;
        end
        m_pc[k] = addr;
        if (hit) m_halt[k] = 1;
      end else if (branch) begin
        m_pc[k] = addr;
        if (hit) m_halt[k] = 1;
      end else if (inc) begin
        m_pc[k] = seq;
      end
    end
  endtask

  task automatic check_all();
    check("model_pc_a",  32'(pc_a),     32'(m_pc[0]));
    check("model_hlt_a", 32'(halted_a), 32'(m_halt[0]));
    check("model_ovf_a", 32'(ovf_a),    32'(m_ovf[0]));
    check("model_unf_a", 32'(unf_a),    32'(m_unf[0]));
    check("model_dep_a", 32'(dep_a),    32'(m_n[0]));
    check("model_pc_b",  32'(pc_b),     32'(m_pc[1]));
    check("model_hlt_b", 32'(halted_b), 32'(m_halt[1]));
    check("model_ovf_b", 32'(ovf_b),    32'(m_ovf[1]));
    check("model_unf_b", 32'(unf_b),    32'(m_unf[1]));
    check("model_dep_b", 32'(dep_b),    32'(m_n[1]));
  endtask

  // Drive one cycle of strobes, clock it, advance the model, compare #1 later.
  task automatic drive(input bit r, input bit e, input bit i, input bit b,
                       input bit c, input bit t, input logic [15:0] a);
    areset = r; en = e; inc = i; branch = b; call = c; ret = t; addr = a;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  logic [15:0] wrap_exp [3];
  logic [15:0] ret_exp  [4];

  initial begin
    areset = 1'b1; en = 1'b1; inc = 1'b0; branch = 1'b0; call = 1'b0;
    ret = 1'b0; addr = '0;
    wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001};
    ret_exp  = '{16'h0301, 16'h0201, 16'h0101, 16'h0007};

    // Reset
    drive(1, 1, 0, 0, 0, 0, 16'h0);
    check("rst_pc_a",  32'(pc_a),     32'h0010);
    check("rst_hlt_a", 32'(halted_a), 32'h0);
    check("rst_dep_a", 32'(dep_a),    32'h0);
    check("rst_pc_b",  32'(pc_b),     32'hFFFE);

    // Increment with wrap, then stall
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0, 16'h0);
      check("wrap_pc_b", 32'(pc_b), 32'(wrap_exp[i]));
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 0, 0, 16'h0);
      check("stall_pc_b", 32'(pc_b), 32'h0001);
    end

    // Call / return
    drive(0, 1, 0, 1, 0, 0, 16'h0005);
    check("br_pc_a", 32'(pc_a), 32'h0005);
    drive(0, 1, 0, 0, 1, 0, 16'h0040);
    check("call_pc_a",  32'(pc_a),  32'h0040);
    check("call_dep_a", 32'(dep_a), 32'h1);
    drive(0, 1, 0, 0, 0, 1, 16'h0);
    check("ret_pc_a",  32'(pc_a),  32'h0006);
    check("ret_dep_a", 32'(dep_a), 32'h0);

    // Overflow then underflow
    for (int i = 1; i <= 5; i++) drive(0, 1, 0, 0, 1, 0, 16'(i * 16'h0100));
    check("ovf_flag_a", 32'(ovf_a), 32'h1);
    check("ovf_dep_a",  32'(dep_a), 32'h4);
    check("ovf_pc_a",   32'(pc_a),  32'h0500);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 1, 16'h0);
      check("lifo_pc_a", 32'(pc_a), 32'(ret_exp[i]));
    end
    drive(0, 1, 0, 0, 0, 1, 16'h0);
    check("unf_flag_a", 32'(unf_a), 32'h1);
    check("unf_pc_a",   32'(pc_a),  32'h0008);

    // Halt on jump-to-self, then frozen
    drive(0, 1, 0, 1, 0, 0, 16'h0008);
    check("self_hlt_a", 32'(halted_a), 32'h1);
    drive(0, 1, 1, 0, 0, 0, 16'h0);
    drive(0, 1, 0, 1, 0, 0, 16'h0123);
    drive(0, 1, 0, 0, 1, 0, 16'h0200);
    check("frz_pc_a",  32'(pc_a),     32'h0008);
    check("frz_dep_a", 32'(dep_a),    32'h0);
    check("frz_hlt_a", 32'(halted_a), 32'h1);

    // Halt on negative target (only the instance that enables it)
    drive(1, 1, 0, 0, 0, 0, 16'h0);
    drive(0, 1, 0, 1, 0, 0, 16'h8000);
    check("neg_hlt_a", 32'(halted_a), 32'h1);
    check("neg_pc_a",  32'(pc_a),     32'h8000);
    check("neg_hlt_b", 32'(halted_b), 32'h0);

    // Priority: ret wins over call and branch; reset wins over inc
    drive(1, 1, 0, 0, 0, 0, 16'h0);
    drive(0, 1, 0, 1, 0, 0, 16'h0032);
    drive(0, 1, 0, 0, 1, 0, 16'h0050);
    drive(0, 1, 0, 1, 1, 1, 16'h0070);
    check("prio_pc_a",  32'(pc_a),  32'h0033);
    check("prio_dep_a", 32'(dep_a), 32'h0);
    drive(1, 1, 1, 0, 0, 0, 16'h0);
    check("rst_inc_pc_a", 32'(pc_a), 32'h0010);

    // Reset between call and ret discards the stack
    drive(0, 1, 0, 0, 1, 0, 16'h0060);
    drive(1, 1, 0, 0, 0, 0, 16'h0);
    drive(0, 1, 0, 0, 0, 1, 16'h0);
    check("midrst_unf_a", 32'(unf_a), 32'h1);
    check("midrst_pc_a",  32'(pc_a),  32'h0011);

    // Random strobes
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = m_pc[0];
      else if (sel == 1) a = 16'($urandom_range(0, 65535));
      else               a = 16'($urandom_range(0, 255));
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
